// File: rtl/dma_rx_frame_if.sv
// Handshake and bus bundle between the RX DMA engine and its surroundings
// (RX FIFO, CPU bus arbiter, RAM port, status).
interface dma_rx_frame_if #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned ADDR_W = 8,
  parameter int unsigned CNT_W  = 2
);
  logic              Ena;
  logic [DATA_W-1:0] RX_Data;
  logic              RX_Empty;
  logic              Data_Read;
  logic              Bus_req;
  logic              Bus_grant;
  logic [ADDR_W-1:0] Address;
  logic [DATA_W-1:0] Databus;
  logic              Cs;
  logic              Wena;
  logic              Busy;
  logic [CNT_W-1:0]  Byte_Cnt;
  logic              Dma_End;
  logic              Dma_Err;

  // DMA engine side
  modport master (
    input  Ena, RX_Data, RX_Empty, Bus_grant,
    output Data_Read, Bus_req, Address, Databus, Cs, Wena,
           Busy, Byte_Cnt, Dma_End, Dma_Err
  );

  // FIFO / arbiter / RAM / controller side
  modport slave (
    output Ena, RX_Data, RX_Empty, Bus_grant,
    input  Data_Read, Bus_req, Address, Databus, Cs, Wena,
           Busy, Byte_Cnt, Dma_End, Dma_Err
  );
endinterface

// File: rtl/dma_rx_frame.sv
// Serial-RX DMA engine: moves one FRAME_BYTES frame from the RX FIFO into RAM at
// BASE_ADDR while holding the system bus, with inter-byte timeout and grant-loss abort.
module dma_rx_frame #(
  parameter int unsigned       DATA_W      = 8,
  parameter int unsigned       ADDR_W      = 8,
  parameter int unsigned       FRAME_BYTES = 3,
  parameter logic [ADDR_W-1:0] BASE_ADDR   = '0,
  parameter int unsigned       TIMEOUT     = 16,
  parameter int unsigned       CNT_W       = $clog2(FRAME_BYTES + 1)
) (
  input  logic           Clk,
  input  logic           Rst_n,
  dma_rx_frame_if.master bus
);

  localparam int unsigned       TMR_W      = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CNT_W-1:0]  IDX_LAST   = CNT_W'(FRAME_BYTES - 1);
  localparam logic [TMR_W-1:0]  TMR_LAST   = TMR_W'(TIMEOUT - 1);
  localparam bit                TIMEOUT_EN = (TIMEOUT != 0);

  typedef enum logic [2:0] {
    S_IDLE,
    S_BUS_REQ,
    S_READ,
    S_WRITE,
    S_WAIT_DATA,
    S_DONE,
    S_ABORT
  } state_e;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   idx_q, idx_d;
  logic [TMR_W-1:0]   timer_q, timer_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;

  logic               grant_lost_c;
  logic               data_read_c;
  logic               bus_req_c;
  logic               cs_c;
  logic               wena_c;
  logic               busy_c;
  logic               dma_end_c;
  logic               dma_err_c;
  logic [ADDR_W-1:0]  addr_c;
  logic [DATA_W-1:0]  databus_c;
  logic [DATA_W-1:0]  rx_byte_c;
  logic [ADDR_W-1:0]  wr_addr_c;

  assign rx_byte_c = bus.RX_Data;
  assign wr_addr_c = BASE_ADDR + ADDR_W'(idx_q);

  // The bus is only meaningful to us while we are moving data.
  assign grant_lost_c = !bus.Bus_grant &&
                        ((state_q == S_READ) || (state_q == S_WRITE) || (state_q == S_WAIT_DATA));

  // State, byte index, timeout timer and byte counter
  always_ff @(posedge Clk) begin
    if (!Rst_n) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
      timer_q <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      timer_q <= timer_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next state and Moore outputs; Ena low and grant loss gate the decoded outputs
  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    timer_d     = timer_q;
    cnt_d       = cnt_q;
    data_read_c = 1'b0;
    bus_req_c   = 1'b0;
    cs_c        = 1'b0;
    wena_c      = 1'b0;
    dma_end_c   = 1'b0;
    dma_err_c   = 1'b0;
    addr_c      = '0;
    databus_c   = '0;
    busy_c      = (state_q != S_IDLE);

    unique case (state_q)
      S_IDLE: begin
        if (!bus.RX_Empty) begin
          state_d = S_BUS_REQ;
          idx_d   = '0;
          cnt_d   = '0;
        end
      end

      S_BUS_REQ: begin
        bus_req_c = 1'b1;
        if (bus.Bus_grant) begin
          state_d = S_READ;
        end
      end

      S_READ: begin
        bus_req_c = 1'b1;
        if (grant_lost_c) begin
          state_d = S_ABORT;
        end else begin
          data_read_c = 1'b1;
          state_d     = S_WRITE;
        end
      end

      S_WRITE: begin
        bus_req_c = 1'b1;
        if (grant_lost_c) begin
          state_d = S_ABORT;
        end else begin
          cs_c      = 1'b1;
          wena_c    = 1'b1;
          addr_c    = wr_addr_c;
          databus_c = rx_byte_c;
          cnt_d     = idx_q + CNT_W'(1);
          if (idx_q == IDX_LAST) begin
            state_d = S_DONE;
          end else begin
            idx_d = idx_q + CNT_W'(1);
            if (!bus.RX_Empty) begin
              state_d = S_READ;
            end else begin
              state_d = S_WAIT_DATA;
              timer_d = '0;
            end
          end
        end
      end

      S_WAIT_DATA: begin
        bus_req_c = 1'b1;
        if (grant_lost_c) begin
          state_d = S_ABORT;
        end else if (!bus.RX_Empty) begin
          state_d = S_READ;
        end else if (TIMEOUT_EN && (timer_q == TMR_LAST)) begin
          state_d = S_ABORT;
        end else begin
          timer_d = timer_q + TMR_W'(1);
        end
      end

      S_DONE: begin
        dma_end_c = 1'b1;
        state_d   = S_IDLE;
      end

      S_ABORT: begin
        dma_err_c = 1'b1;
        state_d   = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Disable wins over everything except reset: silent return to IDLE.
    if (!bus.Ena) begin
      state_d     = S_IDLE;
      idx_d       = '0;
      timer_d     = '0;
      data_read_c = 1'b0;
      bus_req_c   = 1'b0;
      cs_c        = 1'b0;
      wena_c      = 1'b0;
      dma_end_c   = 1'b0;
      dma_err_c   = 1'b0;
      busy_c      = 1'b0;
      addr_c      = '0;
      databus_c   = '0;
    end
  end

  assign bus.Data_Read = data_read_c;
  assign bus.Bus_req   = bus_req_c;
  assign bus.Cs        = cs_c;
  assign bus.Wena      = wena_c;
  assign bus.Address   = addr_c;
  assign bus.Databus   = databus_c;
  assign bus.Busy      = busy_c;
  assign bus.Byte_Cnt  = cnt_q;
  assign bus.Dma_End   = dma_end_c;
  assign bus.Dma_Err   = dma_err_c;

endmodule
